// File: rtl/dwt_pkg.sv
// Shared types and constants for the LeGall 5/3 lifting stages.
// The stage state struct keeps each stage's FSM visible in one place.
package dwt_pkg;

  localparam int LIFT_RND = 2;
  localparam int SH_PRED  = 1;
  localparam int SH_UPD   = 2;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  // pend: an (even, odd) pair is held waiting for the next even sample.
  typedef struct packed {
    phase_e phase;
    logic   first;
    logic   pend;
  } stage_state_t;

  localparam stage_state_t STAGE_START = '{phase: PH_EVEN, first: 1'b1, pend: 1'b0};

  function automatic int out_w(input int data_w, input int levels);
    return data_w + 2 * levels;
  endfunction

endpackage

// File: rtl/dwt53_lift_stage.sv
// One level of the 5/3 lifting transform with symmetric edge extension.
// Handshake: valid_i qualifies data_i/last_i each cycle, no backpressure; valid_o is a one-cycle pulse.
module dwt53_lift_stage
  import dwt_pkg::*;
#(
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic signed [W-1:0] data_i,
  input  logic                last_i,
  output logic                valid_o,
  output logic signed [W-1:0] l_o,
  output logic signed [W-1:0] h_o,
  output logic                last_o,
  output logic                err_o
);

  stage_state_t        state_q, state_d;
  logic signed [W-1:0] x_even_q, x_even_d, x_odd_q, x_odd_d, d_prev_q, d_prev_d;
  logic signed [W-1:0] l_q, l_d, h_q, h_d;
  logic                valid_q, valid_d, last_q, last_d;
  logic signed [W-1:0] odd_src, next_even, pred, d_c, d_left, upd, s_c;
  logic signed [W:0]   pred_sum, upd_sum;

  // Closing pair: on EVEN the new sample is x[2n+2]; on ODD+last mirror x[N]=x[N-2].
  always_comb begin
    odd_src   = (state_q.phase == PH_ODD) ? data_i : x_odd_q;
    next_even = (state_q.phase == PH_ODD) ? x_even_q : data_i;
    pred_sum  = (W+1)'(x_even_q) + (W+1)'(next_even);
    pred      = W'(pred_sum >>> SH_PRED);
    d_c       = odd_src - pred;
    d_left    = state_q.first ? d_c : d_prev_q;
    upd_sum   = (W+1)'(d_left) + (W+1)'(d_c) + (W+1)'(LIFT_RND);
    upd       = W'(upd_sum >>> SH_UPD);
    s_c       = x_even_q + upd;
  end

  always_comb begin
    state_d  = state_q;
    x_even_d = x_even_q;
    x_odd_d  = x_odd_q;
    d_prev_d = d_prev_q;
    l_d      = l_q;
    h_d      = h_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    err_o    = 1'b0;
    if (valid_i) begin
      if (state_q.phase == PH_EVEN) begin
        if (state_q.pend) begin
          valid_d       = 1'b1;
          l_d           = s_c;
          h_d           = d_c;
          d_prev_d      = d_c;
          state_d.first = 1'b0;
        end
        // A last on an even sample means an odd-length frame: drop it and restart.
        if (last_i) begin
          err_o   = 1'b1;
          state_d = STAGE_START;
        end else begin
          x_even_d      = data_i;
          state_d.phase = PH_ODD;
          state_d.pend  = 1'b0;
        end
      end else if (last_i) begin
        valid_d = 1'b1;
        last_d  = 1'b1;
        l_d     = s_c;
        h_d     = d_c;
        state_d = STAGE_START;
      end else begin
        x_odd_d       = data_i;
        state_d.phase = PH_EVEN;
        state_d.pend  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STAGE_START;
      x_even_q <= '0;
      x_odd_q  <= '0;
      d_prev_q <= '0;
      l_q      <= '0;
      h_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_even_q <= x_even_d;
      x_odd_q  <= x_odd_d;
      d_prev_q <= d_prev_d;
      l_q      <= l_d;
      h_q      <= h_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign l_o     = l_q;
  assign h_o     = h_q;
  assign last_o  = last_q;

endmodule

// File: rtl/dwt53_multilevel.sv
// Multi-level 1-D LeGall 5/3 DWT: level k consumes the L band of level k-1.
// Every level's H band is output along with the final L band; err is sticky until reset.
module dwt53_multilevel
  import dwt_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int LEVELS = 2,
  localparam int OUT_W  = out_w(DATA_W, LEVELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic [LEVELS-1:0]        h_valid,
  output logic [LEVELS*OUT_W-1:0]  h_data,
  output logic [LEVELS-1:0]        h_last,
  output logic                     l_valid,
  output logic signed [OUT_W-1:0]  l_data,
  output logic                     l_last,
  output logic                     err
);

  logic [LEVELS:0]         st_valid, st_last;
  logic signed [OUT_W-1:0] st_data [LEVELS+1];
  logic [LEVELS-1:0]       st_err;
  logic                    err_q, err_d;

  assign st_valid[0] = in_valid;
  assign st_last[0]  = in_last;
  assign st_data[0]  = OUT_W'(in_data);

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    dwt53_lift_stage #(.W(OUT_W)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .valid_i (st_valid[k]),
      .data_i  (st_data[k]),
      .last_i  (st_last[k]),
      .valid_o (st_valid[k+1]),
      .l_o     (st_data[k+1]),
      .h_o     (h_data[k*OUT_W +: OUT_W]),
      .last_o  (st_last[k+1]),
      .err_o   (st_err[k])
    );
  end

  assign err_d = err_q | (|st_err);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign h_valid = st_valid[LEVELS:1];
  assign h_last  = st_last[LEVELS:1];
  assign l_valid = st_valid[LEVELS];
  assign l_data  = st_data[LEVELS];
  assign l_last  = st_last[LEVELS];
  assign err     = err_q;

endmodule

// File: tb/tb_dwt53_multilevel.sv
// Directed bench for dwt53_multilevel: a one-level and a two-level instance share clock and reset.
module tb_dwt53_multilevel;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // One-level instance, OUT_W = 10
  logic       in_valid1, in_last1;
  logic [7:0] in_data1;
  logic [0:0] h_valid1, h_last1;
  logic [9:0] h_data1, l_data1;
  logic       l_valid1, l_last1, err1;

  // Two-level instance, OUT_W = 12
  logic        in_valid2, in_last2;
  logic [7:0]  in_data2;
  logic [1:0]  h_valid2, h_last2;
  logic [23:0] h_data2;
  logic [11:0] l_data2;
  logic        l_valid2, l_last2, err2;

  dwt53_multilevel #(.DATA_W(8), .LEVELS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1), .in_last(in_last1),
    .h_valid(h_valid1), .h_data(h_data1), .h_last(h_last1),
    .l_valid(l_valid1), .l_data(l_data1), .l_last(l_last1), .err(err1)
  );

  dwt53_multilevel #(.DATA_W(8), .LEVELS(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2),
    .h_valid(h_valid2), .h_data(h_data2), .h_last(h_last2),
    .l_valid(l_valid2), .l_data(l_data2), .l_last(l_last2), .err(err2)
  );

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drive1(input int d, input bit last);
    in_data1 = 8'(d); in_valid1 = 1'b1; in_last1 = last;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_last1 = 1'b0;
  endtask

  task automatic drive2(input bit v, input int d, input bit last);
    in_data2 = 8'(d); in_valid2 = v; in_last2 = last;
    @(posedge clk); #1;
    in_valid2 = 1'b0; in_last2 = 1'b0;
  endtask

  // Observed/expected packing for the one-level instance; data is masked when not valid.
  function automatic logic [23:0] obs1();
    return {l_valid1, h_valid1, l_last1, h_last1,
            l_valid1 ? l_data1 : 10'd0, h_valid1[0] ? h_data1 : 10'd0};
  endfunction

  function automatic logic [23:0] exp1(input int v, input int k, input int l, input int h);
    logic b, kb;
    b  = (v != 0);
    kb = (k != 0);
    return {b, b, kb, kb, b ? 10'(l) : 10'd0, b ? 10'(h) : 10'd0};
  endfunction

  function automatic logic [41:0] obs2();
    return {h_valid2, h_last2, l_valid2, l_last2,
            h_valid2[0] ? h_data2[11:0] : 12'd0,
            h_valid2[1] ? h_data2[23:12] : 12'd0,
            l_valid2 ? l_data2 : 12'd0};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({h_valid1, h_data1, h_last1, l_valid1, l_data1, l_last1, err1} !== '0) begin
      errors++;
      $display("FAIL reset_l1: got %h required 0",
               {h_valid1, h_data1, h_last1, l_valid1, l_data1, l_last1, err1});
    end
    checks++;
    if ({h_valid2, h_data2, h_last2, l_valid2, l_data2, l_last2, err2} !== '0) begin
      errors++;
      $display("FAIL reset_l2: got %h required 0",
               {h_valid2, h_data2, h_last2, l_valid2, l_data2, l_last2, err2});
    end
  endtask

  task automatic test_basic();
    int xs[5] = '{10, 20, 30, 40, 0};
    int vs[5] = '{1, 1, 1, 1, 0};
    int ls[5] = '{0, 0, 0, 1, 0};
    logic [23:0] ex[5];
    ex = '{exp1(0,0,0,0), exp1(0,0,0,0), exp1(1,0,10,0), exp1(1,1,33,10), exp1(0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      if (vs[i] != 0) drive1(xs[i], ls[i] != 0);
      else begin @(posedge clk); #1; end
      checks++;
      if (obs1() !== ex[i]) begin
        errors++;
        $display("FAIL basic step %0d: got %h required %h", i, obs1(), ex[i]);
      end
    end
  endtask

  task automatic test_negative();
    int xs[4] = '{0, -3, 0, 0};
    logic [23:0] ex[4];
    ex = '{exp1(0,0,0,0), exp1(0,0,0,0), exp1(1,0,-1,-3), exp1(1,1,-1,0)};
    for (int i = 0; i < 4; i++) begin
      drive1(xs[i], i == 3);
      checks++;
      if (obs1() !== ex[i]) begin
        errors++;
        $display("FAIL negative step %0d: got %h required %h", i, obs1(), ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs[4] = '{5, 9, -8, 0};
    int ls[4] = '{0, 1, 0, 1};
    logic [23:0] ex[4];
    ex = '{exp1(0,0,0,0), exp1(1,1,7,4), exp1(0,0,0,0), exp1(1,1,-4,8)};
    for (int i = 0; i < 4; i++) begin
      drive1(xs[i], ls[i] != 0);
      checks++;
      if (obs1() !== ex[i]) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h required %h", i, obs1(), ex[i]);
      end
    end
  endtask

  task automatic test_level2_full_rate();
    // {h_valid[1:0], h_last[1:0], l_valid, l_last} after each clock
    logic [5:0] ctl[10] = '{6'b00_00_00, 6'b00_00_00, 6'b01_00_00, 6'b00_00_00, 6'b01_00_00,
                            6'b00_00_00, 6'b01_00_00, 6'b11_01_10, 6'b10_10_11, 6'b00_00_00};
    logic [41:0] ex;
    for (int i = 0; i < 10; i++) begin
      drive2(i < 8, 16, i == 7);
      ex = {ctl[i], 12'd0, 12'd0, ctl[i][1] ? 12'd16 : 12'd0};
      checks++;
      if (obs2() !== ex) begin
        errors++;
        $display("FAIL level2_full step %0d: got %h required %h", i, obs2(), ex);
      end
    end
  endtask

  task automatic test_level2_gaps();
    logic [12:0] exp_q[3][$];
    logic [9:0]  cyc_q[$];
    logic [9:0]  c;
    for (int i = 0; i < 3; i++) exp_q[0].push_back({1'b0, 12'd0});
    exp_q[0].push_back({1'b1, 12'd0});
    exp_q[1].push_back({1'b0, 12'd0});
    exp_q[1].push_back({1'b1, 12'd0});
    exp_q[2].push_back({1'b0, 12'd16});
    exp_q[2].push_back({1'b1, 12'd16});
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) cyc_q.push_back(10'd0);
      cyc_q.push_back({1'b1, (i == 7), 8'd16});
    end
    repeat (5) cyc_q.push_back(10'd0);
    while (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      drive2(c[9], int'(c[7:0]), c[8]);
      for (int b = 0; b < 3; b++) begin
        logic        vld;
        logic [12:0] got;
        case (b)
          0:       begin vld = h_valid2[0]; got = {h_last2[0], h_data2[11:0]};  end
          1:       begin vld = h_valid2[1]; got = {h_last2[1], h_data2[23:12]}; end
          default: begin vld = l_valid2;    got = {l_last2, l_data2};           end
        endcase
        if (vld) begin
          checks++;
          if (exp_q[b].size() == 0) begin
            errors++;
            $display("FAIL level2_gaps band %0d: got %h required no output", b, got);
          end else begin
            if (got !== exp_q[b][0]) begin
              errors++;
              $display("FAIL level2_gaps band %0d: got %h required %h", b, got, exp_q[b][0]);
            end
            void'(exp_q[b].pop_front());
          end
        end
      end
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (exp_q[b].size() != 0) begin
        errors++;
        $display("FAIL level2_gaps_drain band %0d: got %0d missing outputs required 0", b, exp_q[b].size());
      end
    end
  endtask

  task automatic test_reset_abort();
    int xs[4] = '{10, 20, 30, 40};
    logic [23:0] ex[4];
    ex = '{exp1(0,0,0,0), exp1(0,0,0,0), exp1(1,0,10,0), exp1(1,1,33,10)};
    drive1(10, 0);
    drive1(20, 0);
    drive1(30, 0);
    do_reset();
    checks++;
    if ({obs1(), err1} !== 25'd0) begin
      errors++;
      $display("FAIL abort_reset: got %h required 0", {obs1(), err1});
    end
    for (int i = 0; i < 4; i++) begin
      drive1(xs[i], i == 3);
      checks++;
      if (obs1() !== ex[i]) begin
        errors++;
        $display("FAIL abort_frame step %0d: got %h required %h", i, obs1(), ex[i]);
      end
    end
  endtask

  task automatic test_odd_frame_error();
    int xs[5] = '{1, 2, 3, 5, 9};
    int ls[5] = '{0, 0, 1, 0, 1};
    int er[5] = '{0, 0, 1, 1, 1};
    logic [23:0] ex[5];
    ex = '{exp1(0,0,0,0), exp1(0,0,0,0), exp1(1,0,1,0), exp1(0,0,0,0), exp1(1,1,7,4)};
    for (int i = 0; i < 5; i++) begin
      drive1(xs[i], ls[i] != 0);
      checks++;
      if (obs1() !== ex[i] || err1 !== er[i][0]) begin
        errors++;
        $display("FAIL odd_frame step %0d: got %h err=%b required %h err=%0d", i, obs1(), err1, ex[i], er[i]);
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (err1 !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", err1);
    end
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL err_isolated: got %b required 0", err2);
    end
    do_reset();
    checks++;
    if (err1 !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b required 0", err1);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = '0;
    in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_level2_full_rate();
    test_level2_gaps();
    test_reset_abort();
    test_odd_frame_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
